// File: rtl/ball_engine.sv
// Ball motion, collision latching and game-state control.
// All visible state updates once per frame on the vsync rising edge.
module ball_engine #(
  parameter int LEFT_EDGE     = 32,
  parameter int RIGHT_EDGE    = 608,
  parameter int TOP_EDGE      = 32,
  parameter int BOTTOM_EDGE   = 464,
  parameter int BLOCKS_HSTART = 64,
  parameter int BALL_X0       = 320,
  parameter int BALL_Y0       = 400,
  parameter int SPEED         = 2
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       vsync,
  input  logic       drawing_player,
  input  logic [2:0] drawing_block,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] block_status1,
  output logic [7:0] block_status2,
  output logic [7:0] block_status3,
  output logic       lose,
  output logic       win
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    LOST,
    WON
  } state_t;

  localparam logic [9:0] X_MIN   = 10'(LEFT_EDGE + 3);
  localparam logic [9:0] X_MAX   = 10'(RIGHT_EDGE - 3);
  localparam logic [9:0] Y_MIN   = 10'(TOP_EDGE + 3);
  localparam logic [9:0] Y_LOSS  = 10'(BOTTOM_EDGE);
  localparam logic [9:0] BX0     = 10'(BALL_X0);
  localparam logic [9:0] BY0     = 10'(BALL_Y0);
  localparam logic [9:0] STEP    = 10'(SPEED);
  localparam logic [9:0] BLK_OFF = 10'(BLOCKS_HSTART + 1);

  state_t     state, state_nxt;
  logic       vsync_q;
  logic       tick;
  logic [9:0] hcount_d, vcount_d;
  logic       dx_neg, dy_neg;
  logic       hit_paddle;
  logic       blk_hit;
  logic [2:0] blk_row;
  logic [2:0] blk_col;
  logic [9:0] probe_y;
  logic       at_probe;
  logic [2:0] col;
  logic [2:0] blk_sel;
  logic [9:0] bx_n, by_n;
  logic       dx_n, dy_n;
  logic [7:0] s1_n, s2_n, s3_n;
  logic       win_n, lose_n;

  assign tick     = vsync & ~vsync_q;
  assign probe_y  = dy_neg ? ball_y - 10'd4 : ball_y + 10'd4;
  assign at_probe = (hcount_d == ball_x) && (vcount_d == probe_y);
  assign col      = 3'((hcount_d - BLK_OFF) >> 6);

  // Row under the probe, kept only if that block is still alive.
  always_comb begin
    blk_sel = '0;
    case (drawing_block)
      3'b001:  if (block_status1[col]) blk_sel = 3'b001;
      3'b010:  if (block_status2[col]) blk_sel = 3'b010;
      3'b100:  if (block_status3[col]) blk_sel = 3'b100;
      default: blk_sel = '0;
    endcase
  end

  // Scan delay line and vsync history for edge detection.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q  <= 1'b0;
      hcount_d <= '0;
      vcount_d <= '0;
    end else begin
      vsync_q  <= vsync;
      hcount_d <= hcount;
      vcount_d <= vcount;
    end
  end

  // Latch paddle and first live block hit seen during the frame.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_paddle <= 1'b0;
      blk_hit    <= 1'b0;
      blk_row    <= '0;
      blk_col    <= '0;
    end else if (tick) begin
      hit_paddle <= 1'b0;
      blk_hit    <= 1'b0;
      blk_row    <= '0;
      blk_col    <= '0;
    end else if (at_probe) begin
      if (drawing_player) hit_paddle <= 1'b1;
      if (blk_sel != 3'b000 && !blk_hit) begin
        blk_hit <= 1'b1;
        blk_row <= blk_sel;
        blk_col <= col;
      end
    end
  end

  // Frame-tick game logic: next state, ball, directions, blocks.
  always_comb begin
    state_nxt = state;
    bx_n      = ball_x;
    by_n      = ball_y;
    dx_n      = dx_neg;
    dy_n      = dy_neg;
    s1_n      = block_status1;
    s2_n      = block_status2;
    s3_n      = block_status3;
    win_n     = win;
    lose_n    = lose;
    if (tick) begin
      unique case (state)
        IDLE: if (serve) state_nxt = PLAY;
        PLAY: begin
          if (blk_hit) begin
            if (blk_row[0]) s1_n[blk_col] = 1'b0;
            if (blk_row[1]) s2_n[blk_col] = 1'b0;
            if (blk_row[2]) s3_n[blk_col] = 1'b0;
            dy_n = ~dy_neg;
          end else if (hit_paddle && !dy_neg) begin
            dy_n = 1'b1;
          end
          if (ball_x <= X_MIN) dx_n = 1'b0;
          else if (ball_x >= X_MAX) dx_n = 1'b1;
          if (ball_y <= Y_MIN) dy_n = 1'b0;
          if ({s1_n, s2_n, s3_n} == 24'd0) begin
            state_nxt = WON;
            win_n     = 1'b1;
          end else if (ball_y >= Y_LOSS) begin
            state_nxt = LOST;
            lose_n    = 1'b1;
          end else begin
            bx_n = dx_n ? ball_x - STEP : ball_x + STEP;
            by_n = dy_n ? ball_y - STEP : ball_y + STEP;
          end
        end
        LOST, WON: begin
          if (serve) begin
            state_nxt = IDLE;
            bx_n      = BX0;
            by_n      = BY0;
            dx_n      = 1'b0;
            dy_n      = 1'b1;
            s1_n      = 8'hFF;
            s2_n      = 8'hFF;
            s3_n      = 8'hFF;
            win_n     = 1'b0;
            lose_n    = 1'b0;
          end
        end
      endcase
    end
  end

  // Game state register.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ball_x        <= BX0;
      ball_y        <= BY0;
      dx_neg        <= 1'b0;
      dy_neg        <= 1'b1;
      block_status1 <= 8'hFF;
      block_status2 <= 8'hFF;
      block_status3 <= 8'hFF;
      win           <= 1'b0;
      lose          <= 1'b0;
    end else begin
      state         <= state_nxt;
      ball_x        <= bx_n;
      ball_y        <= by_n;
      dx_neg        <= dx_n;
      dy_neg        <= dy_n;
      block_status1 <= s1_n;
      block_status2 <= s2_n;
      block_status3 <= s3_n;
      win           <= win_n;
      lose          <= lose_n;
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: frame-level game model compared every cycle,
// directed serve/hit/win/lose/reset scenarios plus random stimulus.
module tb_ball_engine;

  logic       pxl_clk;
  logic       reset_n;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       vsync;
  logic       drawing_player;
  logic [2:0] drawing_block;
  logic       serve;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] block_status1;
  logic [7:0] block_status2;
  logic [7:0] block_status3;
  logic       lose;
  logic       win;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  ball_engine dut (
    .pxl_clk(pxl_clk),
    .reset_n(reset_n),
    .hcount(hcount),
    .vcount(vcount),
    .vsync(vsync),
    .drawing_player(drawing_player),
    .drawing_block(drawing_block),
    .serve(serve),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .block_status1(block_status1),
    .block_status2(block_status2),
    .block_status3(block_status3),
    .lose(lose),
    .win(win)
  );

  initial pxl_clk = 1'b0;
  always #5 pxl_clk = ~pxl_clk;

  // Game model: 0 idle, 1 play, 2 lost, 3 won.
  int mstate;
  int mbx, mby;
  bit mdx, mdy;
  bit mst [3][8];
  bit mwin, mlose;
  bit mhp, mbh;
  int mrow, mcol;
  int ph, pv;
  bit pvs;

  function automatic void m_level();
    mstate = 0;
    mbx = 320;
    mby = 400;
    mdx = 0;
    mdy = 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++) mst[r][c] = 1;
    mwin = 0;
    mlose = 0;
  endfunction

  function automatic void m_reset();
    m_level();
    mhp = 0;
    mbh = 0;
    ph = 0;
    pv = 0;
    pvs = 0;
  endfunction

  function automatic int m_probe_y();
    return mdy ? ((mby - 4) & 1023) : ((mby + 4) & 1023);
  endfunction

  function automatic int col_of(int x);
    return (((x - 65) & 1023) >> 6) & 7;
  endfunction

  function automatic void m_frame();
    int alive;
    case (mstate)
      0: if (serve) mstate = 1;
      1: begin
        if (mbh) begin
          mst[mrow][mcol] = 0;
          mdy = !mdy;
        end else if (mhp && !mdy) begin
          mdy = 1;
        end
        if (mbx <= 35) mdx = 0;
        else if (mbx >= 605) mdx = 1;
        if (mby <= 35) mdy = 0;
        alive = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 8; c++) alive += int'(mst[r][c]);
        if (alive == 0) begin
          mstate = 3;
          mwin = 1;
        end else if (mby >= 464) begin
          mstate = 2;
          mlose = 1;
        end else begin
          mbx = mdx ? mbx - 2 : mbx + 2;
          mby = mdy ? mby - 2 : mby + 2;
        end
      end
      default: if (serve) m_level();
    endcase
    mhp = 0;
    mbh = 0;
  endfunction

  function automatic void m_step();
    int r, c;
    if (vsync && !pvs) begin
      m_frame();
    end else if (ph == mbx && pv == m_probe_y()) begin
      if (drawing_player) mhp = 1;
      if (!mbh) begin
        r = (drawing_block == 3'd1) ? 0 :
            (drawing_block == 3'd2) ? 1 :
            (drawing_block == 3'd4) ? 2 : -1;
        c = col_of(ph);
        if (r >= 0 && mst[r][c]) begin
          mbh = 1;
          mrow = r;
          mcol = c;
        end
      end
    end
    ph = int'(hcount);
    pv = int'(vcount);
    pvs = vsync;
  endfunction

  function automatic logic [7:0] row_bits(int r);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = mst[r][i];
    return b;
  endfunction

  always @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  // Cycle compare of every output against the model.
  always @(negedge pxl_clk) begin
    if (cmp_en) begin
      checks++;
      if (ball_x !== 10'(mbx) || ball_y !== 10'(mby) ||
          block_status1 !== row_bits(0) ||
          block_status2 !== row_bits(1) ||
          block_status3 !== row_bits(2) ||
          win !== mwin || lose !== mlose || (win && lose)) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual x=%0d y=%0d s=%h/%h/%h w=%b l=%b required x=%0d y=%0d s=%h/%h/%h w=%b l=%b",
                 $time, ball_x, ball_y, block_status1, block_status2,
                 block_status3, win, lose, mbx, mby, row_bits(0),
                 row_bits(1), row_bits(2), mwin, mlose);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] h, input logic [9:0] v,
                     input logic dp, input logic [2:0] db,
                     input logic vs);
    @(negedge pxl_clk);
    hcount = h;
    vcount = v;
    drawing_player = dp;
    drawing_block = db;
    vsync = vs;
  endtask

  task automatic frame(input logic [2:0] blk, input logic pl,
                       input logic [2:0] blk2);
    logic [9:0] px, py;
    px = 10'(mbx);
    py = 10'(m_probe_y());
    cyc(px, py, 1'b0, 3'd0, 1'b0);
    cyc(10'd0, 10'd0, pl, blk, 1'b0);
    cyc(px, py, 1'b0, 3'd0, 1'b0);
    cyc(10'd0, 10'd0, 1'b0, blk2, 1'b0);
    cyc(10'd0, 10'd0, 1'b0, 3'd0, 1'b1);
    cyc(10'd0, 10'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_x"}, int'(ball_x), 320);
    chk({tag, "_y"}, int'(ball_y), 400);
    chk({tag, "_s1"}, int'(block_status1), 255);
    chk({tag, "_s2"}, int'(block_status2), 255);
    chk({tag, "_s3"}, int'(block_status3), 255);
    chk({tag, "_wl"}, int'({win, lose}), 0);
  endtask

  initial begin
    int c;
    logic [2:0] blk;
    logic [9:0] h, v;
    logic [2:0] db;
    reset_n = 1'b0;
    hcount = '0;
    vcount = '0;
    vsync = 1'b0;
    drawing_player = 1'b0;
    drawing_block = '0;
    serve = 1'b0;
    repeat (3) @(negedge pxl_clk);
    reset_n = 1'b1;
    cmp_en = 1;
    reset_vals("reset");

    serve = 1'b1;
    frame(3'd0, 1'b0, 3'd0);
    serve = 1'b0;
    chk("serve_hold_x", int'(ball_x), 320);
    frame(3'd0, 1'b0, 3'd0);
    chk("f1_x", int'(ball_x), 322);
    chk("f1_y", int'(ball_y), 398);
    frame(3'd0, 1'b0, 3'd0);
    chk("f2_x", int'(ball_x), 324);
    chk("f2_y", int'(ball_y), 396);
    frame(3'd1, 1'b0, 3'd2);
    chk("hit_s1", int'(block_status1), 8'hEF);
    chk("hit_s2", int'(block_status2), 8'hFF);
    chk("hit_x", int'(ball_x), 326);
    chk("hit_y", int'(ball_y), 398);
    frame(3'd1, 1'b0, 3'd0);
    chk("dead_s1", int'(block_status1), 8'hEF);
    chk("dead_y", int'(ball_y), 400);

    for (int n = 0; n < 2000 && mstate == 1; n++) begin
      c = col_of(mbx);
      if (mst[0][c]) blk = 3'd1;
      else if (mst[1][c]) blk = 3'd2;
      else if (mst[2][c]) blk = 3'd4;
      else blk = 3'd0;
      frame(blk, blk == 3'd0 && !mdy, 3'd0);
    end
    chk("win", int'(win), 1);
    chk("win_lose", int'(lose), 0);
    chk("win_s", int'({block_status1, block_status2, block_status3}), 0);

    serve = 1'b1;
    frame(3'd0, 1'b0, 3'd0);
    reset_vals("reserve");
    frame(3'd0, 1'b0, 3'd0);
    serve = 1'b0;
    for (int n = 0; n < 1500 && mstate == 1; n++)
      frame(3'd0, 1'b0, 3'd0);
    chk("lose", int'(lose), 1);
    chk("lose_y", int'(ball_y), 464);
    frame(3'd0, 1'b0, 3'd0);
    chk("lose_frozen_y", int'(ball_y), 464);

    serve = 1'b1;
    frame(3'd0, 1'b0, 3'd0);
    frame(3'd0, 1'b0, 3'd0);
    serve = 1'b0;
    frame(3'd0, 1'b0, 3'd0);
    frame(3'd0, 1'b0, 3'd0);
    cyc(10'(mbx), 10'(m_probe_y()), 1'b0, 3'd0, 1'b0);
    cyc(10'd0, 10'd0, 1'b1, 3'd1, 1'b0);
    #2 reset_n = 1'b0;
    #1 reset_vals("async");
    @(negedge pxl_clk);
    reset_n = 1'b1;
    frame(3'd0, 1'b0, 3'd0);
    chk("post_rst_s1", int'(block_status1), 255);

    for (int i = 0; i < 4000; i++) begin
      h = ($urandom_range(3) == 0) ? 10'(mbx) : 10'($urandom_range(639));
      v = ($urandom_range(3) == 0) ? 10'(m_probe_y())
                                   : 10'($urandom_range(479));
      case ($urandom_range(5))
        0: db = 3'd1;
        1: db = 3'd2;
        2: db = 3'd4;
        default: db = 3'd0;
      endcase
      serve = ($urandom_range(3) == 0);
      cyc(h, v, $urandom_range(3) == 0, db, $urandom_range(11) == 0);
    end

    @(negedge pxl_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LEFT_EDGE, 32: left playfield wall x.
- RIGHT_EDGE, 608: right playfield wall x.
- TOP_EDGE, 32: top wall y.
- BOTTOM_EDGE, 464: loss line y.
- BLOCKS_HSTART, 64: block field left x; column = (x - BLOCKS_HSTART - 1)[8:6].
- BALL_X0, 320: serve x.
- BALL_Y0, 400: serve y.
- SPEED, 2: pixels moved per axis per frame.

REQ-002 Ports (name, direction, width, meaning), one per line:
- pxl_clk, in, 1: pixel clock.
- reset_n, in, 1: asynchronous active-low reset.
- hcount, in, 10: current scan x.
- vcount, in, 10: current scan y.
- vsync, in, 1: frame sync, active high.
- drawing_player, in, 1: paddle under pixel, registered one cycle after hcount/vcount.
- drawing_block, in, 3: block row under pixel (1/2/4, 0 = none), same one-cycle latency.
- serve, in, 1: level launch/restart request.
- ball_x, out, 10: ball centre x.
- ball_y, out, 10: ball centre y.
- block_status1, out, 8: row-1 block alive bits.
- block_status2, out, 8: row-2 block alive bits.
- block_status3, out, 8: row-3 block alive bits.
- lose, out, 1: game lost.
- win, out, 1: game won.

Function
REQ-003 All state is clocked on pxl_clk rising edge; serve and vsync are used as-is (same clock domain).
REQ-004 Frame tick = one-cycle pulse on the cycle vsync is high and its previous registered value is low.
REQ-005 Internal hcount_d/vcount_d = hcount/vcount delayed one cycle; probe samples use these, aligned with drawing_*.
REQ-006 Direction regs dx_neg, dy_neg; probe point = (ball_x, ball_y+4) if dy_neg=0, else (ball_x, ball_y-4).
REQ-007 On cycle hcount_d==probe_x and vcount_d==probe_y: hit_paddle sets if drawing_player=1; block hit latches (row code, column) if drawing_block!=0 AND addressed status bit=1 AND no block hit already latched this frame.
REQ-008 Hits on already-cleared bits are ignored (region flag alone is not a hit).
REQ-009 FSM states: IDLE, PLAY, LOST, WON.
REQ-010 IDLE: ball held at (BALL_X0, BALL_Y0); serve=1 -> PLAY at next frame tick.
REQ-011 PLAY, on frame tick, in order: (a) latched block hit clears its status bit and toggles dy_neg; (b) else hit_paddle with dy_neg=0 sets dy_neg=1; (c) wall bounce: ball_x<=LEFT_EDGE+3 -> dx_neg=0, ball_x>=RIGHT_EDGE-3 -> dx_neg=1, ball_y<=TOP_EDGE+3 -> dy_neg=0; (d) ball moves SPEED per axis in updated directions; (e) latched hits clear.
REQ-012 Block hit and paddle hit in the same frame: block wins; paddle ignored that frame.
REQ-013 Position arithmetic is 10-bit unsigned; wall bounce occurs before any wrap is possible.
REQ-014 PLAY -> LOST on frame tick when ball_y>=BOTTOM_EDGE; lose=1, ball frozen.
REQ-015 PLAY -> WON on frame tick when all 24 status bits are 0 after step (a); win=1, ball frozen.
REQ-016 LOST/WON: serve=1 -> IDLE at next frame tick; status bits return to 8'hFF; win/lose=0; ball at serve point; dx_neg=0, dy_neg=1.
REQ-017 win and lose are never both 1.
REQ-018 Outputs change only on frame-tick cycles, so they stay stable across the visible frame.

Reset
REQ-019 With reset_n=0, immediately and asynchronously: state=IDLE, ball_x=BALL_X0, ball_y=BALL_Y0, dx_neg=0, dy_neg=1, block_status1/2/3=8'hFF, win=0, lose=0, latched hits cleared, vsync history=0.
REQ-020 Reset mid-frame or mid-PLAY discards pending hits; the first frame tick after release is processed from IDLE.

Verification
REQ-021 Serve: reset, serve=1, 2 frames -> ball moves to (322,398), then (324,396).
REQ-022 Block hit: drawing_block=1 at probe (ball_x=100) -> block_status1 bit 0 clears at tick; dy_neg toggles; second hit same frame ignored.
REQ-023 Cleared block: drawing_block=2 at probe over a cleared bit -> no status change, no bounce.
REQ-024 Walls and paddle: ball_x=606 moving right -> next x=604; drawing_player at probe with dy_neg=0 -> dy_neg=1.
REQ-025 Loss/win: ball_y reaches 464 -> lose=1, ball frozen; clearing the last alive bit -> win=1; serve -> IDLE, status bits 8'hFF.
REQ-026 Async reset asserted mid-PLAY -> all outputs at REQ-019 values without a clock edge.
